// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   KEY_MAP   - hex code of each key, indexed {column, row} (row 0 = top row)
//   scan_result_t - outcome of one full scan: valid bit plus 4-bit key code
//   NONE      - scan result meaning "no single key pressed"
package keypad_pkg;

   typedef struct packed {
      logic       valid;
      logic [3:0] code;
   } scan_result_t;

   localparam scan_result_t NONE = '{valid: 1'b0, code: 4'h0};

   // Element [{c, r}]; listed from index 15 (c3 r3) down to index 0 (c0 r0).
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hC, 4'hB, 4'hA,   // column 3
      4'hE, 4'h9, 4'h6, 4'h3,   // column 2
      4'hF, 4'h8, 4'h5, 4'h2,   // column 1
      4'h0, 4'h7, 4'h4, 4'h1    // column 0
   };

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for quasi-static asynchronous inputs.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, both stages load RESET_VAL
//   d     - asynchronous input bus
//   q     - synchronized output, two clk cycles behind d
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with full-scan debouncing.
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   row_n     - keypad rows, active-low, asynchronous to clk
//   col_n     - registered one-hot-low column drive
//   key_code  - hex code of the last accepted key
//   key_valid - one-cycle pulse when a new key press is accepted
//   key_down  - high while the accepted state is a single held key
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam int SW = $clog2(SETTLE_CYCLES);
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [DW-1:0] STAB_MAX    = DW'(DEBOUNCE_SCANS);

   logic [3:0]    row_s;
   logic [1:0]    col;
   logic [1:0]    col_next;
   logic [SW-1:0] settle_cnt;
   logic          sample;

   // press_cnt saturates at 2: only "zero", "one" or "many" matters.
   logic [1:0]    press_cnt, press_cnt_next;
   logic [3:0]    last_code, last_code_next;

   scan_result_t  scan_res;
   scan_result_t  prev_res;
   scan_result_t  accepted;
   logic [DW-1:0] stab_cnt, stab_next;

   sync_2ff #(
      .WIDTH     (4),
      .RESET_VAL (4'b1111)
   ) u_row_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (row_n),
      .q     (row_s)
   );

   assign sample   = (settle_cnt == SETTLE_LAST);
   assign col_next = col + 2'd1;

   // Fold the current column's rows into the running scan accumulator and
   // derive what the scan result would be if this were the last column.
   always_comb begin
      press_cnt_next = press_cnt;
      last_code_next = last_code;
      for (int r = 0; r < 4; r++) begin
         if (!row_s[r]) begin
            if (press_cnt_next != 2'd2) press_cnt_next = press_cnt_next + 2'd1;
            last_code_next = KEY_MAP[{col, 2'(r)}];
         end
      end

      scan_res = NONE;
      if (press_cnt_next == 2'd1) scan_res = '{valid: 1'b1, code: last_code_next};

      if (scan_res == prev_res)
         stab_next = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + DW'(1);
      else
         stab_next = DW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= 2'd0;
         col_n      <= 4'b1110;
         settle_cnt <= '0;
         press_cnt  <= 2'd0;
         last_code  <= 4'h0;
         prev_res   <= NONE;
         accepted   <= NONE;
         stab_cnt   <= '0;
         key_code   <= 4'h0;
         key_valid  <= 1'b0;
         key_down   <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (sample) begin
            settle_cnt <= '0;
            col        <= col_next;
            col_n      <= ~(4'b0001 << col_next);
            if (col == 2'd3) begin
               // End of scan: evaluate and start the next scan's
               // accumulator cleared on the same edge.
               press_cnt <= 2'd0;
               last_code <= 4'h0;
               prev_res  <= scan_res;
               stab_cnt  <= stab_next;
               if (stab_next == STAB_MAX && scan_res != accepted) begin
                  accepted <= scan_res;
                  if (scan_res.valid) begin
                     key_code  <= scan_res.code;
                     key_down  <= 1'b1;
                     key_valid <= 1'b1;
                  end else begin
                     key_down <= 1'b0;
                  end
               end
            end else begin
               press_cnt <= press_cnt_next;
               last_code <= last_code_next;
            end
         end else begin
            settle_cnt <= settle_cnt + SW'(1);
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with a key-event scoreboard.
// A behavioural keypad drives row_n from col_n and the set of pressed keys
// (pressed[{c, r}]). Expected key_valid codes are queued when a press is
// staged; the monitor pops one on every key_valid pulse.
module tb_keypad_scan;

   localparam int SETTLE = 4;
   localparam int DEB    = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_down;

   logic [15:0] pressed = '0;
   int          cyc;
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  exp_code;
   logic [3:0]  exp_col;

   keypad_scan #(
      .SETTLE_CYCLES  (SETTLE),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_down  (key_down)
   );

   // ---------------- clock / reset-relative cycle count ----------------
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // ---------------- keypad model ----------------
   always_comb begin
      row_n = 4'b1111;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (pressed[c*4 + r] && !col_n[c]) row_n[r] = 1'b0;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic nc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Stop at the negedge following the edge where cyc % 16 == ph.
   task automatic wait_phase(input int ph);
      for (int i = 0; i < 17; i++) begin
         if (cyc % 16 == ph) break;
         @(negedge clk);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n && key_valid) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_pulse: got pulse with code %0h, expected no pulse", key_code);
         end else begin
            exp_code = exp_q.pop_front();
            check("pulse_code", {4'h0, key_code}, {4'h0, exp_code});
            check("pulse_key_down", {7'h0, key_down}, 8'h01);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset and column walk
      nc(3);
      check("rst_col_n", {4'h0, col_n}, 8'h0E);
      check("rst_key_valid", {7'h0, key_valid}, 8'h00);
      check("rst_key_down", {7'h0, key_down}, 8'h00);
      check("rst_key_code", {4'h0, key_code}, 8'h00);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         exp_col = ~(4'b0001 << ((k / 4) % 4));
         check("col_walk", {4'h0, col_n}, {4'h0, exp_col});
         nc(1);
      end
      nc(40);
      check("idle_key_down", {7'h0, key_down}, 8'h00);

      // Single press of key 6 (column 2, row 1), held about 5 scans
      pressed[9] = 1'b1;
      exp_q.push_back(4'h6);
      nc(72);
      check("press6_seen", 8'(exp_q.size()), 8'd0);
      check("press6_down", {7'h0, key_down}, 8'h01);
      check("press6_code", {4'h0, key_code}, 8'h06);
      nc(8);
      pressed[9] = 1'b0;
      nc(20);
      check("rel6_still_down", {7'h0, key_down}, 8'h01);
      nc(52);
      check("rel6_down", {7'h0, key_down}, 8'h00);
      check("rel6_code_held", {4'h0, key_code}, 8'h06);

      // Bounce on key 5 (column 1, row 1): 10-cycle toggles, then hold
      wait_phase(5);
      pressed[5] = 1'b1; nc(10);
      pressed[5] = 1'b0; nc(10);
      pressed[5] = 1'b1; nc(10);
      pressed[5] = 1'b0; nc(10);
      pressed[5] = 1'b1;
      exp_q.push_back(4'h5);
      nc(72);
      check("bounce5_seen", 8'(exp_q.size()), 8'd0);
      check("bounce5_code", {4'h0, key_code}, 8'h05);
      pressed[5] = 1'b0;
      nc(72);
      check("rel5_down", {7'h0, key_down}, 8'h00);

      // Multi-press 1 + D rejected, then 1 alone accepted
      pressed[0]  = 1'b1;
      pressed[15] = 1'b1;
      nc(80);
      check("multi_down", {7'h0, key_down}, 8'h00);
      check("multi_code_held", {4'h0, key_code}, 8'h05);
      pressed[15] = 1'b0;
      exp_q.push_back(4'h1);
      nc(72);
      check("press1_seen", 8'(exp_q.size()), 8'd0);
      check("press1_code", {4'h0, key_code}, 8'h01);

      // Direct changes at a scan boundary: 1 -> 9 -> C
      wait_phase(15);
      pressed[0]  = 1'b0;
      pressed[10] = 1'b1;
      exp_q.push_back(4'h9);
      nc(72);
      check("press9_seen", 8'(exp_q.size()), 8'd0);
      check("press9_code", {4'h0, key_code}, 8'h09);
      wait_phase(15);
      pressed[10] = 1'b0;
      pressed[14] = 1'b1;
      exp_q.push_back(4'hC);
      for (int i = 0; i < 5; i++) begin
         nc(16);
         check("chg_down_held", {7'h0, key_down}, 8'h01);
      end
      check("pressc_seen", 8'(exp_q.size()), 8'd0);
      check("pressc_code", {4'h0, key_code}, 8'h0C);
      pressed[14] = 1'b0;
      nc(72);
      check("relc_down", {7'h0, key_down}, 8'h00);

      // Reset while key 6 sits at stab_cnt = 2
      wait_phase(15);
      pressed[9] = 1'b1;
      nc(40);
      rst_n = 1'b0;
      #1;
      check("midrst_col_n", {4'h0, col_n}, 8'h0E);
      check("midrst_key_valid", {7'h0, key_valid}, 8'h00);
      check("midrst_key_down", {7'h0, key_down}, 8'h00);
      check("midrst_key_code", {4'h0, key_code}, 8'h00);
      nc(3);
      rst_n = 1'b1;
      nc(44);
      check("fresh_debounce_down", {7'h0, key_down}, 8'h00);
      exp_q.push_back(4'h6);
      nc(30);
      check("fresh6_seen", 8'(exp_q.size()), 8'd0);
      check("fresh6_code", {4'h0, key_code}, 8'h06);
      check("fresh6_down", {7'h0, key_down}, 8'h01);

      pressed = '0;
      nc(10);
      check("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
